mem_stall_resp: RTL and testbench
=================================

MEM_STALL_RESP -- requirements
Module: mem_stall_resp

Interface
REQ-001 Parameter LATENCY, default 4, cycles from request acceptance to Done; legal range 1..15.
REQ-002 Parameter AW, default 8, word-address width; storage holds 2^AW 16-bit words.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 Addr  input  16  byte address from initiator; Addr[0] must be 0; Addr[AW:1] selects word; bits above AW ignored (aliasing).
REQ-006 DataIn  input  16  write data.
REQ-007 Rd  input  1  read request, held by initiator until Done.
REQ-008 Wr  input  1  write request, held by initiator until Done.
REQ-009 DataOut  output  16  read data, valid only in the Done cycle of a read.
REQ-010 Stall  output  1  initiator must hold its request and freeze.
REQ-011 Done  output  1  one-cycle completion pulse.
REQ-012 err  output  1  illegal request flag.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, BUSY, DONE.
REQ-014 In IDLE, a legal request (exactly one of Rd/Wr high, Addr[0]=0) SHALL latch op, word address and DataIn, load the counter with LATENCY-1, and go to BUSY, or to DONE directly when LATENCY=1.
REQ-015 In BUSY, the counter SHALL decrement each cycle; when it reaches 0 the FSM SHALL go to DONE on the next edge.
REQ-016 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-017 Stall SHALL be combinational and equal to (IDLE and legal request) or BUSY; Stall SHALL be 0 in DONE.
REQ-018 Done SHALL be 1 only in DONE.
REQ-019 Timeline: request sampled in cycle 0; Done asserted in cycle LATENCY; the next request is accepted no earlier than cycle LATENCY+1.
REQ-020 A write SHALL commit the latched DataIn to storage on the edge entering DONE.
REQ-021 A read SHALL drive the stored word at the latched address on DataOut during DONE.
REQ-022 DataOut SHALL be 0 in every other cycle.
REQ-023 Rd, Wr, Addr and DataIn changes during BUSY or DONE SHALL be ignored.
REQ-024 A request still present in the DONE cycle SHALL NOT start a new access.
REQ-025 In IDLE, when Rd and Wr are both 1, or a request has Addr[0]=1, err SHALL be 1 combinationally in that cycle. In that case Stall SHALL be 0, no state change SHALL occur, and storage SHALL be untouched.
REQ-026 err SHALL be 0 in BUSY and DONE.
REQ-027 A read of a just-written word SHALL return the written value, with no bypass hazards.

Reset
REQ-028 While rst=1, asynchronously: state SHALL be IDLE, counter 0, latched op/address/data 0, and all storage words 0.
REQ-029 While rst=1, outputs SHALL be Stall=0, Done=0, err=0, DataOut=0, regardless of Rd/Wr.
REQ-030 Reset asserted in BUSY SHALL abort the access with no storage write and no Done pulse.
REQ-031 After rst deasserts, the first rising edge SHALL be able to accept a request.

Verification
REQ-032 LATENCY=4, write: Wr=1, Addr=0x0010, DataIn=0xBEEF at cycle 0. Required: Stall=1 in cycles 0-3; Done=1 and Stall=0 in cycle 4; no err.
REQ-033 Read-back: Rd=1, Addr=0x0010 at cycle 5. Required: Done=1 and DataOut=0xBEEF in cycle 9; DataOut=0 in cycles 5-8 and 10.
REQ-034 Illegal requests: Rd=Wr=1 at Addr=0x0002 gives err=1, Stall=0, state IDLE. Rd=1 at Addr=0x0003 gives err=1. A following read of 0x0002 returns 0x0000.
REQ-035 Aliasing, AW=8: write 0x1234 to Addr=0x0204. A read of Addr=0x0004 returns 0x1234.
REQ-036 Abort: Wr=1, Addr=0x0020, DataIn=0xAAAA, rst pulsed in cycle 2. Required: no Done pulse; a subsequent read of 0x0020 returns 0x0000.
REQ-037 LATENCY=1, back-to-back reads with the request held: Done in cycle 1, the next access accepted in cycle 2, Done again in cycle 3; the request held during DONE does not double-issue.

Source files
------------

// File: rtl/mem_stall_resp.sv
// Single-port word memory behind a stall/done handshake: one access in flight,
// completing LATENCY cycles after it is accepted.
module mem_stall_resp #(
    parameter int LATENCY = 4,
    parameter int AW      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Rd,
    input  logic        Wr,
    output logic [15:0] DataOut,
    output logic        Stall,
    output logic        Done,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int         DEPTH       = 1 << AW;
    localparam logic [3:0] CNT_LOAD    = 4'(LATENCY - 1);
    localparam bit         DIRECT_DONE = (LATENCY == 1);

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           op_wr_q, op_wr_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [15:0]    data_q, data_d;
    logic [15:0]    mem_q [DEPTH];

    logic           req_s;
    logic           legal_s;
    logic           illegal_s;
    logic           commit_s;
    logic           unused_addr_s;

    // Address bits above the word index alias onto the same storage.
    assign unused_addr_s = ^(Addr >> (AW + 1));

    // Request classification: exactly one of Rd/Wr and a word-aligned address.
    always_comb begin
        req_s     = Rd | Wr;
        legal_s   = (Rd ^ Wr) & ~Addr[0];
        illegal_s = req_s & ~legal_s;
    end

    // Next-state, countdown and request latching.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (legal_s) begin
                    op_wr_d = Wr;
                    addr_d  = Addr[AW:1];
                    data_d  = DataIn;
                    if (DIRECT_DONE) begin
                        state_d = DONE;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_LOAD;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                // Leaving BUSY as the counter hits zero puts Done exactly LATENCY cycles after acceptance.
                if (cnt_q == 4'd1) begin
                    state_d = DONE;
                end else begin
                    state_d = BUSY;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        commit_s = (state_d == DONE) && (state_q != DONE);
    end

    // Handshake outputs; all forced low while reset is held.
    always_comb begin
        Stall = ~rst & (((state_q == IDLE) & legal_s) | (state_q == BUSY));
        err   = ~rst & (state_q == IDLE) & illegal_s;
        Done  = ~rst & (state_q == DONE);
        if (~rst && (state_q == DONE) && !op_wr_q) begin
            DataOut = mem_q[addr_q];
        end else begin
            DataOut = 16'd0;
        end
    end

    // FSM and latched request registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            op_wr_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Storage: a write lands on the edge entering DONE, so a following read sees it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 16'd0;
            end
        end else if (commit_s && op_wr_d) begin
            mem_q[addr_d] <= data_d;
        end
    end

endmodule

// File: tb/tb_mem_stall_resp.sv
// Bench for mem_stall_resp: LATENCY=4 and LATENCY=1 instances, directed tables
// plus random transactions against a transaction-level memory model.
module tb_mem_stall_resp;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr, din, dout, addr1, din1, dout1;
    logic        rd, wr, stall, done, err;
    logic        rd1, wr1, stall1, done1, err1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] din;
        logic        st;
        logic        dn;
        logic        er;
        logic [15:0] dout;
    } vec_t;

    vec_t tbl4[$];
    vec_t tbl1[$];
    logic [15:0] ref_mem [16];

    mem_stall_resp #(.LATENCY(LAT), .AW(8)) dut (
        .clk(clk), .rst(rst), .Addr(addr), .DataIn(din), .Rd(rd), .Wr(wr),
        .DataOut(dout), .Stall(stall), .Done(done), .err(err)
    );

    mem_stall_resp #(.LATENCY(1), .AW(8)) dut1 (
        .clk(clk), .rst(rst), .Addr(addr1), .DataIn(din1), .Rd(rd1), .Wr(wr1),
        .DataOut(dout1), .Stall(stall1), .Done(done1), .err(err1)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h, expected %h", nm, $time, got, exp);
        end
    endtask

    task automatic chk4(input string nm, input logic st, input logic dn, input logic er,
                        input logic [15:0] dv);
        chk({nm, ".stall"}, {15'd0, stall}, {15'd0, st});
        chk({nm, ".done"},  {15'd0, done},  {15'd0, dn});
        chk({nm, ".err"},   {15'd0, err},   {15'd0, er});
        chk({nm, ".dout"},  dout, dv);
    endtask

    task automatic chk1(input string nm, input logic st, input logic dn, input logic er,
                        input logic [15:0] dv);
        chk({nm, ".stall"}, {15'd0, stall1}, {15'd0, st});
        chk({nm, ".done"},  {15'd0, done1},  {15'd0, dn});
        chk({nm, ".err"},   {15'd0, err1},   {15'd0, er});
        chk({nm, ".dout"},  dout1, dv);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(logic r, logic w, logic [15:0] a, logic [15:0] d,
                                logic st, logic dn, logic er, logic [15:0] dv);
        vec_t v;
        v.rd = r; v.wr = w; v.addr = a; v.din = d;
        v.st = st; v.dn = dn; v.er = er; v.dout = dv;
        return v;
    endfunction

    task automatic garbage();
        rd   = 1'($urandom);
        wr   = 1'($urandom);
        addr = 16'($urandom);
        din  = 16'($urandom);
    endtask

    // One legal access: Stall for LATENCY cycles, then a single Done cycle.
    task automatic do_txn(input logic is_rd, input logic [15:0] a, input logic [15:0] d,
                          input logic [15:0] exp_dout);
        rd = is_rd; wr = ~is_rd; addr = a; din = d;
        for (int c = 0; c <= LAT; c++) begin
            if (c > 0) garbage();
            @(negedge clk);
            chk4(is_rd ? "rd_txn" : "wr_txn", c < LAT, c == LAT, 1'b0,
                 (c == LAT) ? exp_dout : 16'd0);
            next_cycle();
        end
        rd = 1'b0; wr = 1'b0;
    endtask

    initial begin
        logic [7:0]  w;
        logic [6:0]  hi;
        logic [15:0] a, d;
        int          k;

        // Outputs quiet during reset even with requests present.
        rst = 1'b1; rd = 1'b1; wr = 1'b0; addr = 16'h0010; din = 16'h1111;
        rd1 = 1'b1; wr1 = 1'b0; addr1 = 16'h0010; din1 = 16'h0000;
        @(negedge clk);
        chk4("reset_rd", 1'b0, 1'b0, 1'b0, 16'd0);
        chk1("reset_rd_l1", 1'b0, 1'b0, 1'b0, 16'd0);
        wr = 1'b1;
        #1;
        chk4("reset_rdwr", 1'b0, 1'b0, 1'b0, 16'd0);
        next_cycle();
        rst = 1'b0; rd = 1'b0; wr = 1'b0; rd1 = 1'b0;

        // Write/read-back, illegal requests, aliasing.
        tbl4.push_back(mk(1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b1, 1'b0, 1'b0, 16'h0000));
        for (int i = 0; i < 3; i++)
            tbl4.push_back(mk(1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b1, 1'b0, 1'b0, 16'h0000));
        tbl4.push_back(mk(1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b1, 1'b0, 16'h0000));
        for (int i = 0; i < 4; i++)
            tbl4.push_back(mk(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000));
        tbl4.push_back(mk(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b1, 1'b0, 16'hBEEF));
        tbl4.push_back(mk(1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000));
        tbl4.push_back(mk(1'b1, 1'b1, 16'h0002, 16'h5555, 1'b0, 1'b0, 1'b1, 16'h0000));
        tbl4.push_back(mk(1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000));
        for (int i = 0; i < 4; i++)
            tbl4.push_back(mk(1'b1, 1'b0, 16'h0002, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000));
        tbl4.push_back(mk(1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000));
        tbl4.push_back(mk(1'b0, 1'b1, 16'h0204, 16'h1234, 1'b1, 1'b0, 1'b0, 16'h0000));
        for (int i = 0; i < 3; i++)
            tbl4.push_back(mk(1'b1, 1'b1, 16'h0011, 16'hFFFF, 1'b1, 1'b0, 1'b0, 16'h0000));
        tbl4.push_back(mk(1'b0, 1'b1, 16'h0204, 16'h1234, 1'b0, 1'b1, 1'b0, 16'h0000));
        for (int i = 0; i < 4; i++)
            tbl4.push_back(mk(1'b1, 1'b0, 16'h0004, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000));
        tbl4.push_back(mk(1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h1234));

        foreach (tbl4[i]) begin
            rd = tbl4[i].rd; wr = tbl4[i].wr; addr = tbl4[i].addr; din = tbl4[i].din;
            @(negedge clk);
            chk4($sformatf("tbl4[%0d]", i), tbl4[i].st, tbl4[i].dn, tbl4[i].er, tbl4[i].dout);
            next_cycle();
        end
        rd = 1'b0; wr = 1'b0;

        // Reset in the middle of a write aborts it.
        wr = 1'b1; addr = 16'h0020; din = 16'hAAAA;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk4("abort_pre", 1'b1, 1'b0, 1'b0, 16'd0);
            next_cycle();
        end
        rst = 1'b1;
        @(negedge clk);
        chk4("abort_in_rst", 1'b0, 1'b0, 1'b0, 16'd0);
        next_cycle();
        rst = 1'b0; wr = 1'b0;
        for (int c = 0; c < LAT + 2; c++) begin
            @(negedge clk);
            chk4("abort_post", 1'b0, 1'b0, 1'b0, 16'd0);
            next_cycle();
        end
        do_txn(1'b1, 16'h0020, 16'h0000, 16'h0000);

        // LATENCY=1: write, then back-to-back reads with Rd held across DONE.
        tbl1.push_back(mk(1'b0, 1'b1, 16'h0006, 16'h5A5A, 1'b1, 1'b0, 1'b0, 16'h0000));
        tbl1.push_back(mk(1'b0, 1'b1, 16'h0006, 16'h5A5A, 1'b0, 1'b1, 1'b0, 16'h0000));
        tbl1.push_back(mk(1'b1, 1'b0, 16'h0006, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000));
        tbl1.push_back(mk(1'b1, 1'b0, 16'h0006, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h5A5A));
        tbl1.push_back(mk(1'b1, 1'b0, 16'h0006, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000));
        tbl1.push_back(mk(1'b1, 1'b0, 16'h0006, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h5A5A));
        tbl1.push_back(mk(1'b0, 1'b0, 16'h0006, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000));
        foreach (tbl1[i]) begin
            rd1 = tbl1[i].rd; wr1 = tbl1[i].wr; addr1 = tbl1[i].addr; din1 = tbl1[i].din;
            @(negedge clk);
            chk1($sformatf("tbl1[%0d]", i), tbl1[i].st, tbl1[i].dn, tbl1[i].er, tbl1[i].dout);
            next_cycle();
        end
        rd1 = 1'b0; wr1 = 1'b0;

        // Random traffic; storage is all-zero since the abort reset.
        for (int i = 0; i < 16; i++) ref_mem[i] = 16'd0;
        for (int i = 0; i < 80; i++) begin
            k  = $urandom_range(0, 9);
            w  = 8'($urandom_range(0, 15));
            hi = 7'($urandom);
            a  = {hi, w, 1'b0};
            d  = 16'($urandom);
            if (k < 2) begin
                rd = 1'b0; wr = 1'b0; addr = a; din = d;
                @(negedge clk);
                chk4("rnd_idle", 1'b0, 1'b0, 1'b0, 16'd0);
                next_cycle();
            end else if (k == 2) begin
                if ($urandom_range(0, 1) == 1) begin
                    rd = 1'b1; wr = 1'b1; addr = a;
                end else begin
                    rd = 1'($urandom); wr = ~rd; addr = a | 16'h0001;
                end
                din = d;
                @(negedge clk);
                chk4("rnd_illegal", 1'b0, 1'b0, 1'b1, 16'd0);
                next_cycle();
                rd = 1'b0; wr = 1'b0;
            end else if (k < 6) begin
                do_txn(1'b0, a, d, 16'd0);
                ref_mem[w[3:0]] = d;
            end else begin
                do_txn(1'b1, a, 16'd0, ref_mem[w[3:0]]);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
